if_stage_mo: RTL

Parametrised instruction-fetch stage supporting multiple outstanding inst-SRAM read requests, with an N-entry fetched-instruction queue feeding decode.
- Generates the fetch PC, issues pipelined requests on the addr_ok/data_ok SRAM-like interface, and queues returned instructions with their PC.
- Handles redirects (exception, ertn, branch) by flushing the queue and silently discarding every in-flight response.
- Sits between the PC source and ID, with the same ds_allowin / fs_to_ds_valid handshake as the rest of the pipeline.

---
 rtl/if_stage_mo.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/if_stage_mo.sv
// Instruction-fetch stage: pipelined inst-SRAM requests with several in flight,
// and the returned words queued together with their PCs in front of decode.
module if_stage_mo #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_inst,
  output logic [31:0] fs_pc,
  output logic        fs_adef_ex,
  input  logic        br_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int FW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic          adef_block;
  logic          started;

  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   q_pc   [IBUF_DEPTH];
  logic [31:0]   q_inst [IBUF_DEPTH];
  logic          q_adef [IBUF_DEPTH];

  logic [31:0]   pf_pc  [MAX_OUTSTANDING];
  logic [FW-1:0] pf_rd;
  logic [FW-1:0] pf_wr;

  logic          redirect;
  logic [31:0]   redirect_target;
  logic          misaligned;
  logic [15:0]   live;
  logic [15:0]   used;
  logic          req;
  logic          accept;
  logic          resp_keep;
  logic          adef_push;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] q_next(input logic [PW-1:0] p);
    return (p == PW'(IBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [FW-1:0] pf_next(input logic [FW-1:0] p);
    return (p == FW'(MAX_OUTSTANDING - 1)) ? '0 : p + FW'(1);
  endfunction

  assign redirect = wb_ex | ertn_flush | br_taken;

  always_comb begin
    redirect_target = br_target;
    if (wb_ex) begin
      redirect_target = ex_entry;
    end else if (ertn_flush) begin
      redirect_target = ertn_entry;
    end
  end

  // Queue slots already holding entries plus slots promised to live responses.
  assign live = 16'(outstanding) - 16'(discard);
  assign used = 16'(count) + live;

  assign misaligned = fetch_pc[1:0] != 2'b00;

  assign req = started & !redirect & !br_stall & !adef_block & !misaligned
             & (outstanding < OW'(MAX_OUTSTANDING))
             & (used < 16'(IBUF_DEPTH));

  assign accept    = req & inst_sram_addr_ok;
  assign resp_keep = inst_sram_data_ok & (discard == '0) & !redirect;

  // The adef entry waits for every live response so program order is kept.
  assign adef_push = started & !redirect & misaligned & !adef_block
                   & (live == 16'd0) & (count < CW'(IBUF_DEPTH));

  assign push = resp_keep | adef_push;
  assign pop  = (count != '0) & ds_allowin & !redirect;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      adef_block  <= 1'b0;
      started     <= 1'b0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      pf_rd       <= '0;
      pf_wr       <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + OW'(accept) - OW'(inst_sram_data_ok);
      if (accept) begin
        pf_wr <= pf_next(pf_wr);
      end
      if (inst_sram_data_ok) begin
        pf_rd <= pf_next(pf_rd);
      end
      if (redirect) begin
        fetch_pc   <= redirect_target;
        adef_block <= 1'b0;
        discard    <= outstanding - OW'(inst_sram_data_ok);
        count      <= '0;
        head       <= '0;
        tail       <= '0;
      end else begin
        if (accept) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (adef_push) begin
          adef_block <= 1'b1;
        end
        if (inst_sram_data_ok && discard != '0) begin
          discard <= discard - OW'(1);
        end
        if (push) begin
          tail <= q_next(tail);
        end
        if (pop) begin
          head <= q_next(head);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: count and the FIFO pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      pf_pc[pf_wr] <= fetch_pc;
    end
    if (push) begin
      q_pc[tail]   <= resp_keep ? pf_pc[pf_rd] : fetch_pc;
      q_inst[tail] <= resp_keep ? inst_sram_rdata : 32'd0;
      q_adef[tail] <= adef_push;
    end
  end

  assign fs_to_ds_valid = count != '0;
  assign fs_pc          = fs_to_ds_valid ? q_pc[head] : 32'd0;
  assign fs_inst        = fs_to_ds_valid ? q_inst[head] : 32'd0;
  assign fs_adef_ex     = fs_to_ds_valid & q_adef[head];

  assign inst_sram_req   = req;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0000;
  assign inst_sram_addr  = req ? fetch_pc : 32'd0;
  assign inst_sram_wdata = 32'd0;

endmodule
